// File: rtl/trade_beep_sequencer.sv
// Turns matched-trade events into queued fixed-length square-wave beeps for the I2S driver.
// Pitch follows the latched trade price: higher price -> longer half-period -> lower tone.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | silent; starts the next beep when any events are queued
// TONE   | square wave running for BEEP_CYCLES cycles
// GAP    | enforced silence of GAP_CYCLES cycles before returning to IDLE
module trade_beep_sequencer #(
    parameter int unsigned BASE_HALF_PERIOD = 56818,
    parameter int unsigned PRICE_STEP       = 64,
    parameter int unsigned BEEP_CYCLES      = 5000000,
    parameter int unsigned GAP_CYCLES       = 2500000,
    parameter logic [15:0] AMPLITUDE        = 16'h2000,
    parameter int unsigned MAX_PENDING      = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        trigger,
    input  logic [7:0]  trade_price,
    input  logic        mute,
    output logic [15:0] sample,
    output logic        busy,
    output logic [3:0]  pending,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TONE = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [23:0] BEEP_LOAD = 24'(BEEP_CYCLES - 1);
    localparam logic [23:0] GAP_LOAD  = 24'(GAP_CYCLES - 1);
    localparam logic [3:0]  PEND_MAX  = 4'(MAX_PENDING);
    localparam logic [15:0] AMP_NEG   = (~AMPLITUDE) + 16'd1;

    state_t      state_q, state_n;
    logic        trig_d;
    logic [7:0]  price_q;
    logic [3:0]  pend_q, pend_n;
    logic [23:0] dur_q, dur_n;
    logic [23:0] ph_q, ph_n;
    logic [23:0] half_q, half_n;
    logic [23:0] half_calc;
    logic        pol_q, pol_n;
    logic [15:0] sample_q, sample_n;
    logic        ovf_q, ovf_n;
    logic        evt;
    logic        start;

    assign evt       = trigger & ~trig_d;
    assign start     = (state_q == S_IDLE) && (pend_q != 4'd0);
    assign half_calc = 24'(BASE_HALF_PERIOD) + 24'(price_q) * 24'(PRICE_STEP);

    always_comb begin
        state_n = state_q;
        dur_n   = dur_q;
        ph_n    = ph_q;
        half_n  = half_q;
        pol_n   = pol_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_TONE;
                    dur_n   = BEEP_LOAD;
                    half_n  = half_calc;
                    ph_n    = half_calc - 24'd1;
                    pol_n   = 1'b1;
                end
            end
            S_TONE: begin
                if (ph_q == 24'd0) begin
                    ph_n  = half_q - 24'd1;
                    pol_n = ~pol_q;
                end else begin
                    ph_n = ph_q - 24'd1;
                end
                if (dur_q == 24'd0) begin
                    state_n = S_GAP;
                    dur_n   = GAP_LOAD;
                end else begin
                    dur_n = dur_q - 24'd1;
                end
            end
            S_GAP: begin
                if (dur_q == 24'd0) begin
                    state_n = S_IDLE;
                end else begin
                    dur_n = dur_q - 24'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // An event coinciding with a start cancels out, so it can never overflow.
        pend_n = pend_q;
        ovf_n  = 1'b0;
        if (evt && !start) begin
            if (pend_q == PEND_MAX) begin
                ovf_n = 1'b1;
            end else begin
                pend_n = pend_q + 4'd1;
            end
        end else if (start && !evt) begin
            pend_n = pend_q - 4'd1;
        end

        sample_n = 16'd0;
        if (state_n == S_TONE && !mute) begin
            sample_n = pol_n ? AMPLITUDE : AMP_NEG;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            trig_d   <= 1'b0;
            price_q  <= 8'd0;
            pend_q   <= 4'd0;
            dur_q    <= 24'd0;
            ph_q     <= 24'd0;
            half_q   <= 24'd0;
            pol_q    <= 1'b0;
            sample_q <= 16'd0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_n;
            trig_d   <= trigger;
            if (evt) begin
                price_q <= trade_price;
            end
            pend_q   <= pend_n;
            dur_q    <= dur_n;
            ph_q     <= ph_n;
            half_q   <= half_n;
            pol_q    <= pol_n;
            sample_q <= sample_n;
            ovf_q    <= ovf_n;
        end
    end

    assign busy     = (state_q != S_IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;
    assign sample   = sample_q;

endmodule

// File: tb/tb_trade_beep_sequencer.sv
// Bench for trade_beep_sequencer: directed scenarios plus random traffic, every cycle
// checked against a timeline model (beep start time + arithmetic on elapsed cycles).
module tb_trade_beep_sequencer;

    localparam int          BASE = 4;
    localparam int          STEP = 1;
    localparam int          BEEP = 20;
    localparam int          GAP  = 10;
    localparam int          MAXP = 15;
    localparam logic [15:0] AMP  = 16'h2000;
    localparam logic [15:0] NEG  = 16'hE000;

    logic        clk = 1'b0;
    logic        reset;
    logic        trigger;
    logic [7:0]  trade_price;
    logic        mute;
    logic [15:0] sample;
    logic        busy;
    logic [3:0]  pending;
    logic        overflow;

    trade_beep_sequencer #(
        .BASE_HALF_PERIOD(BASE),
        .PRICE_STEP      (STEP),
        .BEEP_CYCLES     (BEEP),
        .GAP_CYCLES      (GAP),
        .AMPLITUDE       (AMP),
        .MAX_PENDING     (MAXP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .trigger    (trigger),
        .trade_price(trade_price),
        .mute       (mute),
        .sample     (sample),
        .busy       (busy),
        .pending    (pending),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: queue count, latched price, and the edge index at which the
    // current beep started; everything else is derived from elapsed cycles.
    bit m_trig_d;
    bit m_active;
    int m_price, m_pend, m_start, m_half, m_edge;
    int dut_ovf_cnt, mdl_ovf_cnt, max_pend;

    function automatic int phase_at(int e);
        if (!m_active) return 0;
        if (e - m_start < BEEP) return 1;
        if (e - m_start < BEEP + GAP) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_trig_d = 1'b0;
        m_active = 1'b0;
        m_price  = 0;
        m_pend   = 0;
        m_start  = 0;
        m_half   = 0;
        m_edge   = 0;
    endtask

    task automatic check(input string tag, input logic [15:0] es, input logic eb,
                         input logic [3:0] ep, input logic eo);
        n_cmp++;
        assert (sample === es) else begin
            n_bad++;
            $error("FAIL %s sample got %h exp %h", tag, sample, es);
        end
        n_cmp++;
        assert (busy === eb) else begin
            n_bad++;
            $error("FAIL %s busy got %b exp %b", tag, busy, eb);
        end
        n_cmp++;
        assert (pending === ep) else begin
            n_bad++;
            $error("FAIL %s pending got %0d exp %0d", tag, pending, ep);
        end
        n_cmp++;
        assert (overflow === eo) else begin
            n_bad++;
            $error("FAIL %s overflow got %b exp %b", tag, overflow, eo);
        end
    endtask

    task automatic tick(input string tag);
        bit          ev, st;
        int          ph, t;
        logic [15:0] es;
        logic        eo;
        ev = trigger && !m_trig_d;
        st = (phase_at(m_edge - 1) == 0) && (m_pend > 0);
        if (st) begin
            m_active = 1'b1;
            m_start  = m_edge;
            m_half   = BASE + m_price * STEP;
        end
        eo = 1'b0;
        if (ev && !st) begin
            if (m_pend == MAXP) eo = 1'b1;
            else m_pend++;
        end else if (st && !ev) begin
            m_pend--;
        end
        if (ev) m_price = int'(trade_price);
        m_trig_d = trigger;
        ph = phase_at(m_edge);
        t  = m_edge - m_start;
        es = 16'd0;
        if (ph == 1 && !mute) es = (((t / m_half) % 2) == 0) ? AMP : NEG;
        m_edge++;
        if (eo) mdl_ovf_cnt++;
        @(posedge clk);
        #1;
        if (overflow === 1'b1) dut_ovf_cnt++;
        if (int'(pending) > max_pend) max_pend = int'(pending);
        check(tag, es, (ph != 0), 4'(m_pend), eo);
    endtask

    task automatic pulse(input logic [7:0] p, input string tag);
        trigger     = 1'b1;
        trade_price = p;
        tick(tag);
        trigger = 1'b0;
        tick(tag);
    endtask

    task automatic reset_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("in_reset", 16'd0, 1'b0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        reset       = 1'b1;
        trigger     = 1'b0;
        mute        = 1'b0;
        trade_price = 8'd0;
        dut_ovf_cnt = 0;
        mdl_ovf_cnt = 0;
        max_pend    = 0;
        model_reset();
        #1;
        check("reset_async", 16'd0, 1'b0, 4'd0, 1'b0);
        reset_cycles(3);
        reset = 1'b0;
        model_reset();

        // Held trigger: one event, one beep at price 0.
        trigger     = 1'b1;
        trade_price = 8'd0;
        repeat (50) tick("single_held");
        trigger = 1'b0;
        repeat (5) tick("single_idle");

        // Price 3 -> half period 7.
        pulse(8'd3, "pitch");
        repeat (35) tick("pitch");

        // Three events queued during the first beep; last price (5) applies to all three.
        max_pend = 0;
        pulse(8'd8, "queue");
        pulse(8'd1, "queue");
        pulse(8'd2, "queue");
        pulse(8'd5, "queue");
        repeat (120) tick("queue");
        n_cmp++;
        assert (max_pend === 3) else begin
            n_bad++;
            $error("FAIL queue_depth got %0d exp 3", max_pend);
        end

        // Burst of 1 + 17 events: saturation, overflow pulses, start/event coincidence.
        max_pend    = 0;
        dut_ovf_cnt = 0;
        mdl_ovf_cnt = 0;
        repeat (18) pulse(8'($urandom_range(0, 255)), "burst");
        n_cmp++;
        assert (max_pend === 15) else begin
            n_bad++;
            $error("FAIL burst_saturate got %0d exp 15", max_pend);
        end
        n_cmp++;
        assert (dut_ovf_cnt === mdl_ovf_cnt) else begin
            n_bad++;
            $error("FAIL burst_ovf_pulses got %0d exp %0d", dut_ovf_cnt, mdl_ovf_cnt);
        end
        reset = 1'b1;
        model_reset();
        reset_cycles(2);
        reset = 1'b0;

        // Mute mid-tone, then asynchronous reset mid-tone with four queued.
        repeat (5) pulse(8'($urandom_range(0, 20)), "mute_setup");
        mute = 1'b1;
        repeat (4) tick("muted");
        mute = 1'b0;
        repeat (2) tick("unmuted");
        n_cmp++;
        assert (pending === 4'd4 && busy === 1'b1) else begin
            n_bad++;
            $error("FAIL pre_reset pending %0d busy %b exp 4 1", pending, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        check("reset_mid_tone", 16'd0, 1'b0, 4'd0, 1'b0);
        model_reset();
        reset_cycles(2);
        reset = 1'b0;
        repeat (3) tick("post_reset_idle");

        // Random traffic.
        repeat (600) begin
            trigger     = ($urandom_range(0, 2) == 0);
            trade_price = 8'($urandom_range(0, 255));
            mute        = ($urandom_range(0, 9) == 0);
            tick("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
